symbol_deserializer: RTL and testbench



---
 rtl/symbol_deserializer.sv | 171 +++++++++++++++++
 tb/tb_symbol_deserializer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/symbol_deserializer.sv
// symbol_deserializer
//   Receive-side word assembler. SYMW-bit symbols arrive with a level strobe;
//   each rising edge of the strobe captures one symbol. Symbols are packed
//   MSB-first into a WORDW-bit word that opens with a start-of-word marker
//   (sof). Each finished word is held in a one-entry valid/ready output
//   register until the downstream layer accepts it.
//
// Ports
//   clk          clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   sym          incoming symbol, sampled only on a capture event
//   sym_strobe   level strobe, a 0->1 transition delivers one symbol
//   sof          start-of-word marker, qualified by the capture event
//   word         assembled word, stable while word_valid is high
//   word_valid   word holds a result that has not been consumed
//   word_ready   downstream accepts word when word_valid & word_ready
//   overrun      sticky, a completed word was dropped (output register full)
//   framing_err  one-cycle pulse on a framing violation
//   clear_err    clears overrun (a simultaneous new overrun wins)
module symbol_deserializer #(
    parameter int SYMW  = 8,
    parameter int WORDW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SYMW-1:0]  sym,
    input  logic             sym_strobe,
    input  logic             sof,
    output logic [WORDW-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    output logic             framing_err,
    input  logic             clear_err
);

    localparam int SYMS = WORDW / SYMW;
    localparam int CNTW = (SYMS > 1) ? $clog2(SYMS) : 1;

    generate
        if ((WORDW % SYMW) != 0 || WORDW < SYMW) begin : g_bad_width
            $error("symbol_deserializer: WORDW must be an integer multiple of SYMW");
        end
    endgenerate

    typedef enum logic [0:0] {IDLE, COLLECT} state_t;

    state_t            state_reg, state_next;
    logic [CNTW-1:0]   cnt_reg, cnt_next;
    logic [WORDW-1:0]  shift_data_reg, shift_data_next;
    logic [WORDW-1:0]  word_reg, word_next;
    logic              word_valid_reg, word_valid_next;
    logic              overrun_reg, overrun_next;
    logic              framing_err_reg, framing_err_next;
    logic              strobe_q_reg;

    logic              cap;
    logic              complete;
    logic              out_free;
    logic [WORDW-1:0]  shifted;
    logic [WORDW-1:0]  completed_word;

    assign cap      = sym_strobe & ~strobe_q_reg;
    // Output register can take a new word if empty or being drained this cycle.
    assign out_free = ~word_valid_reg | word_ready;
    // Older symbols move toward the MSB; the newest symbol enters at the LSB.
    assign shifted  = (shift_data_reg << SYMW) | WORDW'(sym);

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        shift_data_next  = shift_data_reg;
        framing_err_next = 1'b0;
        complete         = 1'b0;
        completed_word   = shifted;

        case (state_reg)
            IDLE: begin
                if (cap) begin
                    if (sof) begin
                        if (SYMS == 1) begin
                            // Single-symbol words finish on their own sof.
                            complete        = 1'b1;
                            completed_word  = WORDW'(sym);
                            shift_data_next = '0;
                            cnt_next        = '0;
                        end else begin
                            shift_data_next = WORDW'(sym);
                            cnt_next        = CNTW'(1);
                            state_next      = COLLECT;
                        end
                    end else begin
                        framing_err_next = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (cap) begin
                    if (sof) begin
                        // Early sof: drop the partial word, restart from here.
                        shift_data_next  = WORDW'(sym);
                        cnt_next         = CNTW'(1);
                        framing_err_next = 1'b1;
                    end else if (cnt_reg == CNTW'(SYMS - 1)) begin
                        complete        = 1'b1;
                        shift_data_next = '0;
                        cnt_next        = '0;
                        state_next      = IDLE;
                    end else begin
                        shift_data_next = shifted;
                        cnt_next        = cnt_reg + CNTW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        word_next       = word_reg;
        word_valid_next = word_valid_reg;
        overrun_next    = overrun_reg;

        if (complete && out_free) begin
            word_next       = completed_word;
            word_valid_next = 1'b1;
        end else if (word_valid_reg && word_ready) begin
            word_valid_next = 1'b0;
        end

        // Set has priority over clear.
        if (complete && !out_free) begin
            overrun_next = 1'b1;
        end else if (clear_err) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Strobe treated as already high so a level held through reset
            // does not look like a fresh capture.
            strobe_q_reg    <= 1'b1;
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            shift_data_reg  <= '0;
            word_reg        <= '0;
            word_valid_reg  <= 1'b0;
            overrun_reg     <= 1'b0;
            framing_err_reg <= 1'b0;
        end else begin
            strobe_q_reg    <= sym_strobe;
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            shift_data_reg  <= shift_data_next;
            word_reg        <= word_next;
            word_valid_reg  <= word_valid_next;
            overrun_reg     <= overrun_next;
            framing_err_reg <= framing_err_next;
        end
    end

    assign word        = word_reg;
    assign word_valid  = word_valid_reg;
    assign overrun     = overrun_reg;
    assign framing_err = framing_err_reg;

endmodule

// File: tb/tb_symbol_deserializer.sv
// tb_symbol_deserializer
//   Directed bench for symbol_deserializer (SYMW=8, WORDW=32). Inputs are
//   driven on the falling edge and outputs sampled on the falling edge, so a
//   value registered at a capture edge is visible at the next sample point.
module tb_symbol_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sym;
    logic        sym_strobe;
    logic        sof;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready;
    logic        overrun;
    logic        framing_err;
    logic        clear_err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    symbol_deserializer #(.SYMW(8), .WORDW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .sym         (sym),
        .sym_strobe  (sym_strobe),
        .sof         (sof),
        .word        (word),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overrun     (overrun),
        .framing_err (framing_err),
        .clear_err   (clear_err)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Strobe high for one cycle (capture on the following rising edge), then
    // low; returns at the sample point just after the capture edge.
    task automatic send_sym(input logic s, input logic [7:0] v);
        @(negedge clk);
        sym        = v;
        sof        = s;
        sym_strobe = 1'b1;
        @(negedge clk);
        sym_strobe = 1'b0;
        sof        = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        send_sym(1'b1, t[31:24]);
        send_sym(1'b0, t[23:16]);
        send_sym(1'b0, t[15:8]);
        send_sym(1'b0, t[7:0]);
    endtask

    task automatic do_reset(input logic hold_strobe);
        @(negedge clk);
        rst        = 1'b1;
        sym_strobe = hold_strobe;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sym = '0; sym_strobe = 1'b0; sof = 1'b0;
        word_ready = 1'b1; clear_err = 1'b0;

        // Reset state
        do_reset(1'b0);
        @(negedge clk);
        check_vec("rst_word", word, 32'h0);
        check_vec("rst_valid", {31'd0, word_valid}, 32'd0);
        check_vec("rst_overrun", {31'd0, overrun}, 32'd0);
        check_vec("rst_ferr", {31'd0, framing_err}, 32'd0);

        // Basic word, ready high: valid for exactly one cycle
        send_word(32'hDEADBEEF);
        check_vec("t1_word", word, 32'hDEADBEEF);
        check_vec("t1_valid", {31'd0, word_valid}, 32'd1);
        check_vec("t1_ferr", {31'd0, framing_err}, 32'd0);
        @(negedge clk);
        check_vec("t1_valid_fall", {31'd0, word_valid}, 32'd0);

        // Strobe held high through reset release: no capture
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        check_vec("t2_no_cap_ferr", {31'd0, framing_err}, 32'd0);
        sym_strobe = 1'b0;
        @(negedge clk);
        check_vec("t2_no_cap_ferr2", {31'd0, framing_err}, 32'd0);
        send_sym(1'b0, 8'h55);
        check_vec("t2_ferr_pulse", {31'd0, framing_err}, 32'd1);
        check_vec("t2_valid", {31'd0, word_valid}, 32'd0);
        @(negedge clk);
        check_vec("t2_ferr_end", {31'd0, framing_err}, 32'd0);

        // Early sof restarts the word
        send_sym(1'b1, 8'h11);
        send_sym(1'b0, 8'h22);
        check_vec("t3_ferr_pre", {31'd0, framing_err}, 32'd0);
        send_sym(1'b1, 8'hAA);
        check_vec("t3_ferr_sof", {31'd0, framing_err}, 32'd1);
        send_sym(1'b0, 8'hBB);
        check_vec("t3_ferr_once", {31'd0, framing_err}, 32'd0);
        send_sym(1'b0, 8'hCC);
        send_sym(1'b0, 8'hDD);
        check_vec("t3_word", word, 32'hAABBCCDD);
        check_vec("t3_valid", {31'd0, word_valid}, 32'd1);

        // Overrun with ready low
        @(negedge clk);
        word_ready = 1'b0;
        send_word(32'h01020304);
        check_vec("t4_word1", word, 32'h01020304);
        check_vec("t4_ovr_none", {31'd0, overrun}, 32'd0);
        send_word(32'h05060708);
        check_vec("t4_word_held", word, 32'h01020304);
        check_vec("t4_valid_held", {31'd0, word_valid}, 32'd1);
        check_vec("t4_ovr_set", {31'd0, overrun}, 32'd1);
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check_vec("t4_ovr_clr", {31'd0, overrun}, 32'd0);

        // Accept and complete in the same cycle
        send_sym(1'b1, 8'hCA);
        send_sym(1'b0, 8'hFE);
        send_sym(1'b0, 8'hF0);
        @(negedge clk);
        sym = 8'h0D; sof = 1'b0; sym_strobe = 1'b1; word_ready = 1'b1;
        @(negedge clk);
        sym_strobe = 1'b0; word_ready = 1'b0;
        check_vec("t5_word", word, 32'hCAFEF00D);
        check_vec("t5_valid", {31'd0, word_valid}, 32'd1);
        check_vec("t5_ovr", {31'd0, overrun}, 32'd0);
        word_ready = 1'b1;
        @(negedge clk);
        check_vec("t5_drain", {31'd0, word_valid}, 32'd0);

        // Reset mid-word discards partial content
        send_sym(1'b1, 8'h9A);
        send_sym(1'b0, 8'hBC);
        do_reset(1'b0);
        send_word(32'h12345678);
        check_vec("t6_word", word, 32'h12345678);
        check_vec("t6_valid", {31'd0, word_valid}, 32'd1);
        check_vec("t6_ferr", {31'd0, framing_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
